// File: rtl/fifo_burst_reader.sv
// Read-side burst master: pops len words from a registered-read FIFO and
// streams them out through a 2-entry skid buffer on a valid/ready port.
`timescale 1ns/1ps
module fifo_burst_reader #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len_q;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_delivered;
  logic              r_inflight;
  logic [1:0]        r_buf_count;
  logic [DATA_W-1:0] r_buf [2];
  logic              r_head;
  logic              r_tail;

  logic              w_accept;
  logic              w_last;
  logic              w_credit_ok;
  logic              w_pop;

  assign w_accept = (r_buf_count != 2'd0) & out_ready;
  assign w_last   = w_accept & (r_delivered == (r_len_q - 1'b1));

  // A word in flight from the FIFO already owns a buffer slot; a same-cycle
  // accept frees one, so the credit test adds it to the budget.
  assign w_credit_ok = (({1'b0, r_buf_count} + {2'b00, r_inflight}) <
                        (3'd2 + {2'b00, w_accept}));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (len == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_RUN);
    done      = (r_state == S_FIN);
    w_pop     = (r_state == S_RUN) & ~fifo_empty & (r_issued < r_len_q) & w_credit_ok;
    fifo_rd   = w_pop;
    out_valid = (r_buf_count != 2'd0);
    out_data  = r_buf[r_head];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_q     <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
      r_buf_count <= 2'd0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if ((r_state == S_IDLE) && start && (len != '0)) begin
        r_len_q     <= len;
        r_issued    <= '0;
        r_delivered <= '0;
      end else begin
        if (w_pop) begin
          r_issued <= r_issued + 1'b1;
        end
        if (w_accept) begin
          r_delivered <= r_delivered + 1'b1;
        end
      end
      r_inflight <= w_pop;
      if (r_inflight) begin
        r_buf[r_tail] <= fifo_dout;
        r_tail        <= ~r_tail;
      end
      if (w_accept) begin
        r_head <= ~r_head;
      end
      r_buf_count <= r_buf_count + {1'b0, r_inflight} - {1'b0, w_accept};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(r_inflight && !w_accept && (r_buf_count == 2'd2)));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    !(fifo_rd && fifo_empty));

endmodule
